// File: rtl/stopwatch_ctrl_if.sv
// Key/tick inputs and control strobes between the stopwatch sequencer and its datapath.
// The sequencer owns the slave side; whoever drives the keys and prescaler tick uses master.
interface stopwatch_ctrl_if;
   logic [2:0] key_n;
   logic       tick;
   logic       cnt_en;
   logic       cnt_clr;
   logic       presc_clr;
   logic       lap_load;
   logic       lap_show;
   logic [1:0] state;

   modport master (
      output key_n, tick,
      input  cnt_en, cnt_clr, presc_clr, lap_load, lap_show, state
   );

   modport slave (
      input  key_n, tick,
      output cnt_en, cnt_clr, presc_clr, lap_load, lap_show, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: key synchronizers, debouncers, press detection and the run-control FSM.
//   state | meaning
//   IDLE  | stopped, digits may be cleared
//   RUN   | counting, live digits displayed
//   PAUSE | stopped mid-interval, resume keeps prescaler phase
//   LAP   | counting, display frozen on captured lap value
module stopwatch_ctrl #(
   parameter int FREQ_MHZ    = 50,
   parameter int DEBOUNCE_MS = 10
) (
   input logic             clk,
   input logic             reset,
   stopwatch_ctrl_if.slave bus
);
   localparam int DEB_CYCLES = FREQ_MHZ * 1000 * DEBOUNCE_MS;
   localparam int DW         = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_LAP   = 2'b11
   } state_t;

   logic [2:0]    sync1, sync2;
   logic [1:0]    fill;
   logic [2:0]    armed;
   logic [2:0]    lvl, lvl_d, evt;
   logic [DW-1:0] dcnt [3];

   state_t st, st_nx;
   logic   cnt_en_q, cnt_clr_q, presc_clr_q, lap_load_q, lap_show_q;
   logic   cnt_en_nx, cnt_clr_nx, presc_clr_nx, lap_load_nx;
   logic   ev_clr, ev_start, ev_lap;

   // A key only becomes armed once a real high sample has passed the synchronizer,
   // so a key held down through reset cannot fire on its own after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
         fill  <= 2'b00;
         armed <= 3'b000;
      end else begin
         sync1 <= bus.key_n;
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
         armed <= armed | (sync2 & {3{fill[1]}});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl <= 3'b111;
         for (int i = 0; i < 3; i++) dcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == lvl[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DEB_LAST) begin
               lvl[i]  <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_d <= 3'b111;
         evt   <= 3'b000;
      end else begin
         lvl_d <= lvl;
         evt   <= lvl_d & ~lvl & armed;
      end
   end

   // Only the highest-priority event of a cycle is seen by the FSM.
   assign ev_clr   = evt[0];
   assign ev_start = evt[1] & ~evt[0];
   assign ev_lap   = evt[2] & ~evt[1] & ~evt[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= S_IDLE;
         cnt_en_q    <= 1'b0;
         cnt_clr_q   <= 1'b0;
         presc_clr_q <= 1'b0;
         lap_load_q  <= 1'b0;
         lap_show_q  <= 1'b0;
      end else begin
         st          <= st_nx;
         cnt_en_q    <= cnt_en_nx;
         cnt_clr_q   <= cnt_clr_nx;
         presc_clr_q <= presc_clr_nx;
         lap_load_q  <= lap_load_nx;
         lap_show_q  <= (st_nx == S_LAP);
      end
   end

   always_comb begin
      st_nx        = st;
      cnt_clr_nx   = 1'b0;
      presc_clr_nx = 1'b0;
      lap_load_nx  = 1'b0;
      cnt_en_nx    = bus.tick & ((st == S_RUN) | (st == S_LAP));
      case (st)
         S_IDLE: begin
            if (ev_start) begin
               st_nx        = S_RUN;
               presc_clr_nx = 1'b1;
            end else if (ev_clr) begin
               cnt_clr_nx = 1'b1;
            end
         end
         S_RUN: begin
            if (ev_start) begin
               st_nx = S_PAUSE;
            end else if (ev_lap) begin
               st_nx       = S_LAP;
               lap_load_nx = 1'b1;
            end
         end
         S_LAP: begin
            if (ev_clr) begin
               st_nx = S_RUN;
            end else if (ev_start) begin
               st_nx = S_PAUSE;
            end else if (ev_lap) begin
               lap_load_nx = 1'b1;
            end
         end
         S_PAUSE: begin
            if (ev_clr) begin
               st_nx      = S_IDLE;
               cnt_clr_nx = 1'b1;
            end else if (ev_start) begin
               st_nx = S_RUN;
            end
         end
         default: st_nx = S_IDLE;
      endcase
   end

   assign bus.state     = st;
   assign bus.cnt_en    = cnt_en_q;
   assign bus.cnt_clr   = cnt_clr_q;
   assign bus.presc_clr = presc_clr_q;
   assign bus.lap_load  = lap_load_q;
   assign bus.lap_show  = lap_show_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed key scenarios plus random keys/ticks against a
// run-length / event-schedule model of the stopwatch behaviour.
module tb_stopwatch_ctrl;
   localparam int D = 1000;

   logic clk;
   logic reset;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.FREQ_MHZ(1), .DEBOUNCE_MS(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int tick_rate = 0;
   int edge_cnt = 0;
   int mism = 0;
   int n_en = 0, n_clr = 0, n_presc = 0, n_lap = 0;
   int m_n_en = 0, m_n_clr = 0, m_n_presc = 0, m_n_lap = 0;

   // Model: a press is accepted after D consecutive low samples; its effect appears
   // four edges after the last of those samples. Keys must be seen high after reset first.
   logic [1:0] m_st;
   logic       m_en, m_clr, m_presc, m_lap;
   logic [2:0] m_acc, m_armed, m_act;
   int         m_run [3];
   int         m_edge;
   int         due_q[$];
   int         key_q[$];

   always @(posedge clk) edge_cnt++;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_st = 2'd0; m_en = 0; m_clr = 0; m_presc = 0; m_lap = 0;
         m_acc = 3'b111; m_armed = 3'b000; m_edge = 0;
         for (int k = 0; k < 3; k++) m_run[k] = 0;
         due_q.delete();
         key_q.delete();
      end else begin
         m_act = 3'b000;
         while (due_q.size() > 0 && due_q[0] == m_edge) begin
            m_act[key_q[0]] = 1'b1;
            void'(due_q.pop_front());
            void'(key_q.pop_front());
         end
         m_en = bus.tick && (m_st == 2'd1 || m_st == 2'd3);
         m_clr = 0; m_presc = 0; m_lap = 0;
         if (m_act[0]) begin
            if (m_st == 2'd0) m_clr = 1;
            else if (m_st == 2'd2) begin m_st = 2'd0; m_clr = 1; end
            else if (m_st == 2'd3) m_st = 2'd1;
         end else if (m_act[1]) begin
            if (m_st == 2'd0) begin m_st = 2'd1; m_presc = 1; end
            else if (m_st == 2'd2) m_st = 2'd1;
            else m_st = 2'd2;
         end else if (m_act[2]) begin
            if (m_st == 2'd1 || m_st == 2'd3) begin m_st = 2'd3; m_lap = 1; end
         end
         for (int k = 0; k < 3; k++) begin
            if (bus.key_n[k]) m_armed[k] = 1'b1;
            if (bus.key_n[k] == m_acc[k]) m_run[k] = 0;
            else begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  m_acc[k] = bus.key_n[k];
                  m_run[k] = 0;
                  if (!bus.key_n[k] && m_armed[k]) begin
                     due_q.push_back(m_edge + 4);
                     key_q.push_back(k);
                  end
               end
            end
         end
         m_edge++;
      end
   end

   always @(posedge clk) begin
      #3;
      if ({bus.state, bus.lap_show, bus.cnt_en, bus.cnt_clr, bus.presc_clr, bus.lap_load} !==
          {m_st, (m_st == 2'd3), m_en, m_clr, m_presc, m_lap}) mism++;
      if (bus.cnt_en)    n_en++;
      if (bus.cnt_clr)   n_clr++;
      if (bus.presc_clr) n_presc++;
      if (bus.lap_load)  n_lap++;
      if (m_en)    m_n_en++;
      if (m_clr)   m_n_clr++;
      if (m_presc) m_n_presc++;
      if (m_lap)   m_n_lap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic cyc_step();
      @(negedge clk);
      bus.tick = (tick_rate != 0) && (bus.tick == 1'b0) && ($urandom_range(tick_rate - 1) == 0);
   endtask

   task automatic run(input int n);
      repeat (n) cyc_step();
   endtask

   task automatic press(input int k, input int hold);
      bus.key_n[k] = 1'b0;
      run(hold);
      bus.key_n[k] = 1'b1;
      run(1100);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_cycles"}, 32'(mism), 32'd0);
      check({tag, "_en"},     32'(n_en),    32'(m_n_en));
      check({tag, "_clr"},    32'(n_clr),   32'(m_n_clr));
      check({tag, "_presc"},  32'(n_presc), 32'(m_n_presc));
      check({tag, "_lap"},    32'(n_lap),   32'(m_n_lap));
   endtask

   int t0, t_run, en0, lap0, gap;

   initial begin
      reset = 1'b1;
      bus.key_n = 3'b111;
      bus.tick = 1'b0;
      run(3);
      reset = 1'b0;
      #1;
      check("reset_state", 32'(bus.state), 32'd0);
      check("reset_outs", 32'({bus.cnt_en, bus.cnt_clr, bus.presc_clr, bus.lap_load, bus.lap_show}), 32'd0);
      run(5);

      // Start held for 1200 cycles: one event, RUN 1003 edges after first low sample.
      t0 = edge_cnt + 1;
      t_run = -1;
      bus.key_n = 3'b101;
      for (int i = 0; i < 1200; i++) begin
         cyc_step();
         if (t_run < 0 && bus.state == 2'b01) t_run = edge_cnt;
      end
      bus.key_n = 3'b111;
      run(1100);
      check("start_latency", 32'(t_run - t0), 32'd1003);
      check("start_state", 32'(bus.state), 32'd1);
      check("start_presc_once", 32'(n_presc), 32'd1);
      check_model("start");

      // Ticks in RUN, then PAUSE stops counting, then resume without prescaler restart.
      en0 = n_en;
      for (int i = 0; i < 12; i++) begin
         gap = 40 + int'($urandom_range(20));
         run(gap);
         bus.tick = 1'b1;
      end
      run(5);
      check("run_cnt_en_count", 32'(n_en - en0), 32'd12);
      press(1, int'($urandom_range(1300, 1050)));
      check("pause_state", 32'(bus.state), 32'd2);
      en0 = n_en;
      for (int i = 0; i < 5; i++) begin
         run(50);
         bus.tick = 1'b1;
      end
      run(5);
      check("pause_no_cnt_en", 32'(n_en - en0), 32'd0);
      press(1, int'($urandom_range(1300, 1050)));
      check("resume_state", 32'(bus.state), 32'd1);
      check("resume_no_presc", 32'(n_presc), 32'd1);
      check_model("pause");

      // Two laps, clear releases the lap display, clear in RUN is ignored.
      tick_rate = 9;
      lap0 = n_lap;
      press(2, int'($urandom_range(1300, 1050)));
      press(2, int'($urandom_range(1300, 1050)));
      check("lap_state", 32'(bus.state), 32'd3);
      check("lap_show_on", 32'(bus.lap_show), 32'd1);
      check("lap_load_count", 32'(n_lap - lap0), 32'd2);
      press(0, int'($urandom_range(1300, 1050)));
      check("lap_clear_state", 32'(bus.state), 32'd1);
      check("lap_show_off", 32'(bus.lap_show), 32'd0);
      press(0, int'($urandom_range(1300, 1050)));
      check("run_clear_state", 32'(bus.state), 32'd1);
      check("run_clear_no_clr", 32'(n_clr), 32'd0);
      check_model("lap");

      // Bouncing start key: every low burst is shorter than the debounce window.
      for (int i = 0; i < 10; i++) begin
         bus.key_n[1] = 1'b0;
         run(int'($urandom_range(900, 200)));
         bus.key_n[1] = 1'b1;
         run(50);
      end
      run(1100);
      check("bounce_state", 32'(bus.state), 32'd1);
      check_model("bounce");

      // Clear and start together: clear wins in PAUSE and in IDLE.
      press(1, int'($urandom_range(1300, 1050)));
      check("pair_pre_state", 32'(bus.state), 32'd2);
      bus.key_n = 3'b100;
      run(int'($urandom_range(1300, 1050)));
      bus.key_n = 3'b111;
      run(1100);
      check("pair_pause_state", 32'(bus.state), 32'd0);
      check("pair_pause_clr", 32'(n_clr), 32'd1);
      bus.key_n = 3'b100;
      run(int'($urandom_range(1300, 1050)));
      bus.key_n = 3'b111;
      run(1100);
      check("pair_idle_state", 32'(bus.state), 32'd0);
      check("pair_idle_clr", 32'(n_clr), 32'd2);
      check("pair_presc", 32'(n_presc), 32'd1);
      check_model("pair");

      // Reset during a lap debounce while in LAP; held keys stay silent afterwards.
      press(1, int'($urandom_range(1300, 1050)));
      press(2, int'($urandom_range(1300, 1050)));
      check("pre_reset_lap", 32'(bus.state), 32'd3);
      bus.key_n[2] = 1'b0;
      run(500);
      reset = 1'b1;
      #1;
      check("mid_reset_state", 32'(bus.state), 32'd0);
      check("mid_reset_outs", 32'({bus.cnt_en, bus.cnt_clr, bus.presc_clr, bus.lap_load, bus.lap_show}), 32'd0);
      run(3);
      reset = 1'b0;
      lap0 = n_lap;
      run(1500);
      check("held_lap_state", 32'(bus.state), 32'd0);
      check("held_lap_no_load", 32'(n_lap - lap0), 32'd0);
      bus.key_n[2] = 1'b1;
      run(1100);
      bus.key_n[1] = 1'b0;
      run(300);
      reset = 1'b1;
      run(3);
      reset = 1'b0;
      run(1500);
      check("held_start_no_event", 32'(bus.state), 32'd0);
      bus.key_n[1] = 1'b1;
      run(1100);
      press(1, int'($urandom_range(1300, 1050)));
      check("repress_start", 32'(bus.state), 32'd1);
      check_model("reset");

      // Random key combinations and hold times with random ticks.
      tick_rate = 7;
      for (int i = 0; i < 10; i++) begin
         bus.key_n = ~3'($urandom_range(7, 1));
         run(int'($urandom_range(1400, 200)));
         bus.key_n = 3'b111;
         run(1100);
      end
      check("random_state", 32'(bus.state), 32'(m_st));
      check_model("random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the stopwatch datapath. It synchronizes and debounces the three active-low board keys and runs a four-state control FSM (IDLE/RUN/PAUSE/LAP). It drives the count-enable, clear, prescaler-clear and lap-capture strobes consumed by the digit counters and display registers. It sits between the KEY pins plus the 100 ms prescaler tick and the BCD counter/display datapath.

## Interface
- FREQ_MHZ, 50, clock frequency in MHz
- DEBOUNCE_MS, 10, key stability window in ms; DEB_CYCLES = FREQ_MHZ*1000*DEBOUNCE_MS (localparam, counter width $clog2(DEB_CYCLES+1))
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- key_n  in  3  raw active-low keys: [0] clear, [1] start/stop, [2] lap
- tick  in  1  one-cycle pulse from the 100 ms prescaler
- cnt_en  out  1  one-cycle count strobe to digit counters
- cnt_clr  out  1  one-cycle clear of digit counters
- presc_clr  out  1  one-cycle prescaler restart
- lap_load  out  1  one-cycle capture of current digits into lap display
- lap_show  out  1  level, 1 = display shows frozen lap value
- state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11

## Operation
- Per key: SYNC flop pair (2 stages), then debouncer holding accepted level lvl (reset 1) and counter dcnt.
  - Synced input == lvl: dcnt <= 0.
  - Synced input != lvl: dcnt increments. When dcnt reaches DEB_CYCLES-1, lvl <= synced input and dcnt <= 0.
  - Any bounce back to lvl clears dcnt.
- Press event evt[i]: registered one-cycle pulse when lvl[i] goes 1->0. Releases generate no event.
- Event priority within one cycle: clear > start > lap. Only the highest event acts; the others are discarded, not queued.
- FSM, with outputs pulsed in the same cycle as the state update:
  - IDLE
    - start -> RUN, presc_clr=1.
    - clear -> IDLE, cnt_clr=1.
    - lap ignored.
  - RUN
    - start -> PAUSE.
    - lap -> LAP, lap_load=1.
    - clear ignored (no clear while running).
  - LAP (counting continues)
    - lap -> LAP, lap_load=1 (new lap).
    - clear -> RUN (release lap display).
    - start -> PAUSE.
  - PAUSE
    - start -> RUN, presc_clr=0 (resume mid-interval).
    - clear -> IDLE, cnt_clr=1.
    - lap ignored.
- lap_show = (state==LAP), registered with the state.
- cnt_en <= tick & (state==RUN | state==LAP), registered.
- A tick in the same cycle as a transition uses the pre-transition state.

## Timing
- Reset (async assert, sync-free release): state=IDLE; cnt_en=cnt_clr=presc_clr=lap_load=lap_show=0; lvl=3'b111; dcnt=0; sync flops=1.
- Key low steady from the edge where sync stage 1 first samples 0 (edge 0):
  - sync2 low at edge 1.
  - lvl falls at edge 1+DEB_CYCLES.
  - evt at edge 2+DEB_CYCLES.
  - state/strobes at edge 3+DEB_CYCLES.
- Bounce shorter than DEB_CYCLES consecutive cycles: no event.
- Key held: exactly one event. Re-press requires release accepted (DEB_CYCLES high) first.
- cnt_en follows tick by exactly 1 cycle; tick pulses never merge.
- Strobes (cnt_clr, presc_clr, lap_load) are exactly 1 cycle wide and mutually exclusive.
- Reset mid-debounce or mid-LAP: everything returns to reset values immediately; no event is emitted after release unless the key is re-pressed.

## Test plan
All tests use FREQ_MHZ=1, DEBOUNCE_MS=1, so DEB_CYCLES=1000.
- Reset, then hold key_n=3'b101 (start) low for 1200 cycles -> state 00->01 at cycle 1003 after first sample; presc_clr high for that one cycle; single event only.
- In RUN, pulse tick every 50 cycles -> cnt_en high exactly 1 cycle after each tick. Press start -> state=10, further ticks produce no cnt_en.
- In RUN, press lap twice -> state=11, lap_show=1, two lap_load pulses. Press clear -> state=01, lap_show=0. Press clear again -> no cnt_clr, state stays 01.
- Bounce start key: 10 low pulses of 300 cycles separated by 50 high cycles, then release -> no event, state unchanged.
- Press clear and start with identical timing while in PAUSE -> state=00, cnt_clr=1, start discarded. The same pair in IDLE -> cnt_clr only, state 00.
- Assert reset for 3 cycles during a lap debounce (dcnt≈500) while in LAP -> all outputs 0, state=00. The key, still held after release, produces no event until it is released and pressed again.
